// File: rtl/alarm_pkg.sv
// Shared constants for the multi-zone alarm supervisor: state codes,
// keypad verdict codes and the bit layout of the status word.
package alarm_pkg;

    // FSM state codes as seen on state_out
    localparam logic [2:0] ST_DISARMED = 3'd0;
    localparam logic [2:0] ST_EXIT     = 3'd1;
    localparam logic [2:0] ST_ARMED    = 3'd2;
    localparam logic [2:0] ST_ENTRY    = 3'd3;
    localparam logic [2:0] ST_ALARM    = 3'd4;

    // Keypad verdict codes delivered with key_valid
    localparam logic [1:0] KEY_OK     = 2'd0;
    localparam logic [1:0] KEY_OKNEG  = 2'd1;
    localparam logic [1:0] KEY_ERROR  = 2'd2;
    localparam logic [1:0] KEY_NO_KEY = 2'd3;

    // status_msg = {trip_latch, siren_out, armed_flag}
    localparam int MSG_ARMED_BIT = 0;
    localparam int MSG_SIREN_BIT = 1;
    localparam int MSG_TRIP_LSB  = 2;

endpackage

// File: rtl/alarm_zone_ctrl_if.sv
// Bundle of keypad, sensor, configuration and status signals between the
// alarm supervisor (slave) and its surroundings (master).
interface alarm_zone_ctrl_if #(
    parameter int N_ZONES = 4
);
    logic [N_ZONES-1:0] sensor_in;
    logic [N_ZONES-1:0] zone_delayed;
    logic [N_ZONES-1:0] zone_bypass;
    logic               key_valid;
    logic [1:0]         key_status;
    logic [2:0]         state_out;
    logic               siren_out;
    logic [N_ZONES-1:0] trip_latch;
    logic [N_ZONES+1:0] status_msg;

    modport master (
        output sensor_in, zone_delayed, zone_bypass, key_valid, key_status,
        input  state_out, siren_out, trip_latch, status_msg
    );

    modport slave (
        input  sensor_in, zone_delayed, zone_bypass, key_valid, key_status,
        output state_out, siren_out, trip_latch, status_msg
    );
endinterface

// File: rtl/alarm_delay_counter.sv
// Loadable down-counter shared by the exit, entry and siren timers.
// expire flags the last counted cycle (count of 1 while enabled).
module alarm_delay_counter #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] val,
    input  logic             en,
    output logic             expire
);
    logic [CNT_W-1:0] cnt_reg;

    // Load wins over counting; the count parks at zero once spent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign expire = en && (cnt_reg == CNT_W'(1));
endmodule

// File: rtl/alarm_zone_ctrl.sv
// Multi-zone alarm supervisor: arms/disarms on keypad verdicts, watches
// synchronised zone sensors and drives a siren with automatic cut-off.
module alarm_zone_ctrl
    import alarm_pkg::*;
#(
    parameter int N_ZONES   = 4,
    parameter int CNT_W     = 18,
    parameter int EXIT_DLY  = 15000,
    parameter int ENTRY_DLY = 15000,
    parameter int SIREN_MAX = 60000
) (
    input logic              clk,
    input logic              rst,
    alarm_zone_ctrl_if.slave bus
);
    logic [N_ZONES-1:0] sync1_reg, sync2_reg;
    logic [N_ZONES-1:0] active, newly;
    logic [N_ZONES-1:0] trip_reg, trip_next;
    logic               inst, dly;
    logic [2:0]         state_reg, state_next;
    logic               siren_reg, siren_next;
    logic               cnt_load, cnt_en, cnt_expire;
    logic [CNT_W-1:0]   cnt_val;
    logic               key_ok, key_okneg, key_err;

    // Two-flop synchroniser for the asynchronous zone sensors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= bus.sensor_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign active    = sync2_reg & ~bus.zone_bypass;
    assign inst      = |(active & ~bus.zone_delayed);
    assign dly       = |(active & bus.zone_delayed);
    assign newly     = active & ~trip_reg;
    assign key_ok    = bus.key_valid && (bus.key_status == KEY_OK);
    assign key_okneg = bus.key_valid && (bus.key_status == KEY_OKNEG);
    assign key_err   = bus.key_valid && (bus.key_status == KEY_ERROR);

    // The siren only counts down while sounding; exit/entry always count
    assign cnt_en = (state_reg == ST_EXIT) || (state_reg == ST_ENTRY) ||
                    ((state_reg == ST_ALARM) && siren_reg);

    alarm_delay_counter #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load),
        .val    (cnt_val),
        .en     (cnt_en),
        .expire (cnt_expire)
    );

    // Next-state decision; a key that acts in the current state beats
    // sensors and timer expiry, keys with no meaning there are ignored
    always_comb begin
        state_next = state_reg;
        siren_next = siren_reg;
        trip_next  = trip_reg;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        if ((state_reg == ST_ARMED) || (state_reg == ST_ENTRY) ||
            (state_reg == ST_ALARM)) begin
            trip_next = trip_reg | active;
        end
        case (state_reg)
            ST_DISARMED: begin
                if (key_ok) begin
                    state_next = ST_EXIT;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(EXIT_DLY);
                    trip_next  = '0;
                end
            end
            ST_EXIT: begin
                if (key_okneg) begin
                    state_next = ST_DISARMED;
                end else if (key_err) begin
                    state_next = ST_ALARM;
                end else if (cnt_expire) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (key_okneg) begin
                    state_next = ST_DISARMED;
                end else if (key_err || inst) begin
                    state_next = ST_ALARM;
                end else if (dly) begin
                    state_next = ST_ENTRY;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(ENTRY_DLY);
                end
            end
            ST_ENTRY: begin
                if (key_ok) begin
                    state_next = ST_DISARMED;
                end else if (inst || cnt_expire) begin
                    state_next = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (key_ok) begin
                    state_next = ST_DISARMED;
                end else if (newly != '0) begin
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(SIREN_MAX);
                    siren_next = 1'b1;
                end else if (cnt_expire) begin
                    siren_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_DISARMED;
            end
        endcase
        // Any entry into ALARM starts a fresh siren period
        if ((state_next == ST_ALARM) && (state_reg != ST_ALARM)) begin
            cnt_load   = 1'b1;
            cnt_val    = CNT_W'(SIREN_MAX);
            siren_next = 1'b1;
        end
        if (state_next != ST_ALARM) begin
            siren_next = 1'b0;
        end
    end

    // State, siren and trip memory registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_DISARMED;
            siren_reg <= 1'b0;
            trip_reg  <= '0;
        end else begin
            state_reg <= state_next;
            siren_reg <= siren_next;
            trip_reg  <= trip_next;
        end
    end

    assign bus.state_out  = state_reg;
    assign bus.siren_out  = siren_reg;
    assign bus.trip_latch = trip_reg;
    assign bus.status_msg = {trip_reg, siren_reg, (state_reg != ST_DISARMED)};
endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Bench for alarm_zone_ctrl: scenario table, async reset sequence and
// random traffic, all checked against a deadline-based reference model.
module tb_alarm_zone_ctrl;
    import alarm_pkg::*;

    localparam int NZ      = 4;
    localparam int EXIT_D  = 4;
    localparam int ENTRY_D = 5;
    localparam int SIREN_D = 8;
    localparam logic [3:0] DLY_CFG = 4'b0010;
    localparam logic [3:0] BYP_CFG = 4'b1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alarm_zone_ctrl_if #(.N_ZONES(NZ)) bus ();

    alarm_zone_ctrl #(
        .N_ZONES  (NZ),
        .CNT_W    (18),
        .EXIT_DLY (EXIT_D),
        .ENTRY_DLY(ENTRY_D),
        .SIREN_MAX(SIREN_D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       kv;
        logic [1:0] ks;
        logic [3:0] sens;
        int         n;
        logic [2:0] st;
        logic       sir;
        logic [3:0] trip;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model: timers are absolute edge deadlines, the sensor
    // synchroniser is a two-deep history
    int         m_state;
    bit         m_siren;
    bit   [3:0] m_trip;
    int         m_deadline;
    bit   [3:0] h1, h2;

    function automatic void model_reset();
        m_state = 0; m_siren = 0; m_trip = 0; m_deadline = -1; h1 = 0; h2 = 0;
    endfunction

    function automatic void model_alarm();
        m_state = 4; m_siren = 1; m_deadline = edge_n + SIREN_D;
    endfunction

    function automatic void model_step();
        bit [3:0] act, fresh;
        bit ins, del, tmo, kv;
        int ks;
        act   = h2 & ~BYP_CFG;
        ins   = |(act & ~DLY_CFG);
        del   = |(act & DLY_CFG);
        fresh = act & ~m_trip;
        tmo   = (edge_n == m_deadline);
        kv    = bus.key_valid;
        ks    = int'(bus.key_status);
        if (m_state >= 2 && m_state <= 4) m_trip = m_trip | act;
        case (m_state)
            0: if (kv && ks == 0) begin
                   m_state = 1; m_deadline = edge_n + EXIT_D; m_trip = 0;
               end
            1: if (kv && ks == 1) m_state = 0;
               else if (kv && ks == 2) model_alarm();
               else if (tmo) m_state = 2;
            2: if (kv && ks == 1) m_state = 0;
               else if ((kv && ks == 2) || ins) model_alarm();
               else if (del) begin m_state = 3; m_deadline = edge_n + ENTRY_D; end
            3: if (kv && ks == 0) m_state = 0;
               else if (ins || tmo) model_alarm();
            4: if (kv && ks == 0) begin m_state = 0; m_siren = 0; end
               else if (fresh != 0) begin m_siren = 1; m_deadline = edge_n + SIREN_D; end
               else if (m_siren && tmo) m_siren = 0;
            default: m_state = 0;
        endcase
        h2 = h1;
        h1 = bus.sensor_in;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [31:0] dut_word();
        return {13'd0, bus.state_out, bus.siren_out, bus.trip_latch, bus.status_msg};
    endfunction

    function automatic logic [31:0] model_word();
        logic [2:0] st;
        st = 3'(m_state);
        return {13'd0, st, m_siren, m_trip, m_trip, m_siren, (m_state != 0)};
    endfunction

    // One clock transaction: advance model, clock DUT, compare outputs
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        $display("edge %0d kv=%0b ks=%0d sens=%b -> state=%0d siren=%0b trip=%b msg=%b",
                 edge_n, bus.key_valid, bus.key_status, bus.sensor_in,
                 bus.state_out, bus.siren_out, bus.trip_latch, bus.status_msg);
        check("model", dut_word(), model_word());
        edge_n++;
    endtask

    function automatic void add(logic kv, logic [1:0] ks, logic [3:0] s, int n,
                                logic [2:0] st, logic sir, logic [3:0] tr);
        vec_t v;
        v.kv = kv; v.ks = ks; v.sens = s; v.n = n; v.st = st; v.sir = sir; v.trip = tr;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1;
        bus.sensor_in    = '0;
        bus.zone_delayed = DLY_CFG;
        bus.zone_bypass  = BYP_CFG;
        bus.key_valid    = 1'b0;
        bus.key_status   = KEY_NO_KEY;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {29'd0, bus.state_out}, 32'd0);
        check("reset_outs", {20'd0, bus.siren_out, bus.trip_latch, bus.status_msg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // kv, ks, sensors, edges, expected state/siren/trip after last edge
        add(1, KEY_OK,    4'b0000, 1, 3'd1, 0, 4'b0000); // arm
        add(0, KEY_NO_KEY,4'b0000, 3, 3'd1, 0, 4'b0000);
        add(0, KEY_NO_KEY,4'b0000, 1, 3'd2, 0, 4'b0000); // armed at 4th edge
        add(0, KEY_NO_KEY,4'b0010, 2, 3'd2, 0, 4'b0000); // sync latency
        add(0, KEY_NO_KEY,4'b0010, 1, 3'd3, 0, 4'b0010); // entry
        add(0, KEY_NO_KEY,4'b0010, 4, 3'd3, 0, 4'b0010);
        add(0, KEY_NO_KEY,4'b0010, 1, 3'd4, 1, 4'b0010); // entry timeout
        add(0, KEY_NO_KEY,4'b0010, 7, 3'd4, 1, 4'b0010);
        add(0, KEY_NO_KEY,4'b0010, 1, 3'd4, 0, 4'b0010); // siren cut-off
        add(1, KEY_OK,    4'b0000, 1, 3'd0, 0, 4'b0010); // disarm
        add(1, KEY_OK,    4'b0000, 1, 3'd1, 0, 4'b0000); // rearm clears latch
        add(0, KEY_NO_KEY,4'b0000, 4, 3'd2, 0, 4'b0000);
        add(0, KEY_NO_KEY,4'b0010, 2, 3'd2, 0, 4'b0000);
        add(0, KEY_NO_KEY,4'b0010, 1, 3'd3, 0, 4'b0010);
        add(0, KEY_NO_KEY,4'b0010, 2, 3'd3, 0, 4'b0010);
        add(1, KEY_OK,    4'b0010, 1, 3'd0, 0, 4'b0010); // disarm in time
        add(0, KEY_NO_KEY,4'b0010, 6, 3'd0, 0, 4'b0010);
        add(1, KEY_OK,    4'b0000, 1, 3'd1, 0, 4'b0000);
        add(0, KEY_NO_KEY,4'b0000, 4, 3'd2, 0, 4'b0000);
        add(0, KEY_NO_KEY,4'b1000, 4, 3'd2, 0, 4'b0000); // bypassed zone
        add(0, KEY_NO_KEY,4'b0001, 2, 3'd2, 0, 4'b0000);
        add(0, KEY_NO_KEY,4'b0001, 1, 3'd4, 1, 4'b0001); // instant zone
        add(0, KEY_NO_KEY,4'b0001, 8, 3'd4, 0, 4'b0001);
        add(0, KEY_NO_KEY,4'b0101, 2, 3'd4, 0, 4'b0001);
        add(0, KEY_NO_KEY,4'b0101, 1, 3'd4, 1, 4'b0101); // retrigger
        add(0, KEY_NO_KEY,4'b0101, 7, 3'd4, 1, 4'b0101);
        add(0, KEY_NO_KEY,4'b0101, 1, 3'd4, 0, 4'b0101);
        add(1, KEY_OK,    4'b0000, 1, 3'd0, 0, 4'b0101);
        add(1, KEY_OK,    4'b0000, 1, 3'd1, 0, 4'b0000);
        add(1, KEY_ERROR, 4'b0000, 1, 3'd4, 1, 4'b0000); // error in exit
        add(1, KEY_OK,    4'b0000, 1, 3'd0, 0, 4'b0000);
        add(1, KEY_OK,    4'b0000, 1, 3'd1, 0, 4'b0000);
        add(0, KEY_NO_KEY,4'b0000, 4, 3'd2, 0, 4'b0000);
        add(0, KEY_NO_KEY,4'b0001, 2, 3'd2, 0, 4'b0000);
        add(1, KEY_OKNEG, 4'b0001, 1, 3'd0, 0, 4'b0001); // key beats trip
        add(0, KEY_NO_KEY,4'b0000, 3, 3'd0, 0, 4'b0001);

        foreach (vecs[i]) begin
            bus.key_valid  = vecs[i].kv;
            bus.key_status = vecs[i].ks;
            bus.sensor_in  = vecs[i].sens;
            tick();
            bus.key_valid  = 1'b0;
            bus.key_status = KEY_NO_KEY;
            for (int j = 1; j < vecs[i].n; j++) tick();
            check($sformatf("vec%0d", i),
                  {24'd0, bus.state_out, bus.siren_out, bus.trip_latch},
                  {24'd0, vecs[i].st, vecs[i].sir, vecs[i].trip});
        end

        // Asynchronous reset in the third siren cycle
        bus.key_valid = 1'b1; bus.key_status = KEY_OK; tick();
        bus.key_valid = 1'b0; bus.key_status = KEY_NO_KEY;
        repeat (4) tick();
        bus.sensor_in = 4'b0001;
        repeat (3) tick();
        check("pre_reset_alarm", {28'd0, bus.state_out, bus.siren_out}, {28'd0, ST_ALARM, 1'b1});
        repeat (2) tick();
        bus.sensor_in = '0;
        #2 rst = 1'b1;
        #1;
        check("async_reset_state", {29'd0, bus.state_out}, 32'd0);
        check("async_reset_outs", {20'd0, bus.siren_out, bus.trip_latch, bus.status_msg}, 32'd0);
        #1 rst = 1'b0;
        model_reset();

        // OK verdict without the strobe must not arm
        bus.key_status = KEY_OK;
        repeat (5) tick();
        check("ok_without_valid", {29'd0, bus.state_out}, 32'd0);
        bus.key_status = KEY_NO_KEY;

        // Random traffic against the model
        for (int r = 0; r < 800; r++) begin
            if ($urandom_range(0, 9) == 0)
                bus.sensor_in = bus.sensor_in ^ (4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0)
                bus.sensor_in = '0;
            bus.key_valid  = ($urandom_range(0, 11) == 0);
            bus.key_status = 2'($urandom_range(0, 3));
            tick();
        end
        bus.key_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alarm_zone_ctrl.md
# alarm_zone_ctrl

Multi-zone alarm supervisor, next generation of the main alarm controller. It arms and disarms on keypad verdicts and watches `N_ZONES` sensor inputs. Each zone is instant, entry-delayed or bypassed. Exit delay, entry delay and siren timeout are parametrised, and the siren has an automatic cut-off. It sits between the keyChecker result and the siren driver, and exposes a status word for the serial status transmitter.

## Interface
- `N_ZONES`, 4: number of sensor zones (1..8).
- `CNT_W`, 18: delay counter width.
- `EXIT_DLY`, 15000: cycles from arming to ARMED (≥1, < 2^CNT_W).
- `ENTRY_DLY`, 15000: cycles of grace on a delayed-zone trip (≥1).
- `SIREN_MAX`, 60000: cycles the siren sounds per trigger (≥1).
- `CLK` in 1: single clock; all logic on rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `SENSOR_IN` in N_ZONES: raw zone sensors, asynchronous, 1 = open/tripped.
- `ZONE_DELAYED` in N_ZONES: static config, 1 = entry-delay zone, 0 = instant zone.
- `ZONE_BYPASS` in N_ZONES: static config, 1 = zone ignored.
- `KEY_VALID` in 1: one-cycle strobe marking a new keypad verdict.
- `KEY_STATUS` in 2: keypad verdict, sampled only when `KEY_VALID` is high. Codes: 0 OK, 1 OKNEG, 2 ERROR, 3 NO_KEY.
- `STATE_OUT` out 3: current state code.
- `SIREN_OUT` out 1: siren drive.
- `TRIP_LATCH` out N_ZONES: zones that tripped since the last arming.
- `STATUS_MSG` out N_ZONES+2: `{TRIP_LATCH, SIREN_OUT, STATE_OUT!=DISARMED}`.

## Operation
- States and codes: DISARMED 0, EXIT 1, ARMED 2, ENTRY 3, ALARM 4. Codes 5–7 go to DISARMED on the next edge.
- The FSM only sees synchronised sensors. `SENSOR_IN` passes through a 2-FF synchroniser to give `s_sens`.
- `active` is `s_sens & ~ZONE_BYPASS`. `inst` is `|(active & ~ZONE_DELAYED)`. `dly` is `|(active & ZONE_DELAYED)`.
- A key event is `KEY_VALID` high. Without a key event, the key is treated as NO_KEY.
- In every state, key events take priority over sensors and timer expiry in the same cycle.

State behaviour:
- **DISARMED**
  - OK: go to EXIT, load `EXIT_DLY`, clear `TRIP_LATCH`.
  - Every other key and every sensor is ignored.
- **EXIT**
  - OKNEG: go to DISARMED.
  - ERROR: go to ALARM.
  - Timer expiry: go to ARMED.
  - Sensors are ignored.
- **ARMED**
  - OKNEG: go to DISARMED.
  - ERROR: go to ALARM.
  - Else if `inst`: go to ALARM.
  - Else if `dly`: go to ENTRY and load `ENTRY_DLY`.
- **ENTRY**
  - OK: go to DISARMED.
  - Else if `inst`: go to ALARM.
  - Else on timer expiry: go to ALARM.
  - ERROR does not change state; the timer keeps running.
- **ALARM**
  - OK: go to DISARMED.
  - Siren:
    - Entering ALARM sets `SIREN_OUT` and loads `SIREN_MAX`.
    - On expiry, `SIREN_OUT` clears and the state stays ALARM.
    - A zone newly active, i.e. `active & ~TRIP_LATCH` nonzero, reloads `SIREN_MAX` and sets `SIREN_OUT` again.
- **TRIP_LATCH**
  - In ARMED, ENTRY and ALARM, each cycle ORs in `active`.
  - Held unchanged in DISARMED and EXIT.
  - Cleared only when arming (DISARMED→EXIT) or on reset.
- **SIREN_OUT**: 0 in every state except ALARM.

## Timing
- Reset values: state DISARMED, `SIREN_OUT` 0, `TRIP_LATCH` 0, counter 0, synchroniser 0. All outputs are registered or derived from registers; no input reaches an output combinationally.
- Key latency: a key event sampled at edge k changes `STATE_OUT` after edge k.
- Sensor latency: a sensor level present at edge k first affects state after edge k+2.
- Delays: with delay D, the state changes at exactly the D-th edge after the entering edge. The counter is loaded with D and decrements once per cycle while in the timed state. Expiry is when the counter reads 1.
- Siren timing: `SIREN_OUT` is high for exactly `SIREN_MAX` cycles per trigger unless disarmed earlier.
- Counter reload: leaving a timed state abandons the count. Any reload overrides the count in progress.
- `RST` asserted mid-delay or mid-siren returns everything to reset values asynchronously. No pending event survives.

## Structure
- Package `alarm_pkg` holds the state codes, the KEY_* codes and the `STATUS_MSG` field layout.
- Sub-module `alarm_delay_counter`: a loadable `CNT_W` down-counter with `LOAD`, `VAL`, `EN` and `EXPIRE` (high when count is 1 and EN is high). It is shared by the exit, entry and siren timing.

## Test plan
All scenarios use `N_ZONES`=4, `EXIT_DLY`=4, `ENTRY_DLY`=5, `SIREN_MAX`=8, `ZONE_DELAYED`=4'b0010, `ZONE_BYPASS`=4'b1000.
1. **Arm to ARMED:** OK strobe at edge 0 → `STATE_OUT`=1 after edge 0, `STATE_OUT`=2 after edge 4, `TRIP_LATCH`=0.
2. **Delayed zone, timeout:** from ARMED, raise `SENSOR_IN`[1] → ENTRY 2 edges later, ALARM 5 edges after that, `SIREN_OUT`=1 for 8 cycles then 0 while `STATE_OUT`=4, `TRIP_LATCH`=4'b0010.
3. **Delayed zone, disarm in time:** in ENTRY, OK strobe on the 3rd cycle → DISARMED, `SIREN_OUT` never high, `TRIP_LATCH` retained as 4'b0010.
4. **Instant and bypassed zones:** in ARMED, `SENSOR_IN`=4'b1000 → no change. `SENSOR_IN`=4'b0001 → ALARM. Later `SENSOR_IN`[2] after siren timeout → siren on again for 8 cycles.
5. **Key errors and priority:** ERROR in EXIT → ALARM. OKNEG in ARMED in the same cycle as an instant trip → DISARMED.
6. **Reset mid-activity:** `RST` pulse mid-siren (cycle 3 of 8) → all outputs 0 and DISARMED immediately. `KEY_STATUS`=OK without `KEY_VALID` → no transition.
